// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester byte arbiter with per-requester FIFOs in front of a UART transmitter
// Build option UART_TX_ARB_FIXED_PRIO_EN: requester 0 always wins instead of round-robin.
module uart_tx_arb #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_wr,
    input  logic [7:0]            req0_data,
    output logic [DEPTH_LOG2:0]   req0_level,
    output logic                  req0_full,
    input  logic                  req1_wr,
    input  logic [7:0]            req1_data,
    output logic [DEPTH_LOG2:0]   req1_level,
    output logic                  req1_full,
    input  logic [1:0]            ovf_clr,
    output logic [1:0]            ovf,
    input  logic                  tx_busy,
    input  logic                  tx_end,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  owner,
    output logic                  active
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [7:0]            mem_q [2][DEPTH];
    logic [7:0]            mem_d [2][DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q [2];
    logic [DEPTH_LOG2-1:0] wr_ptr_d [2];
    logic [DEPTH_LOG2-1:0] rd_ptr_q [2];
    logic [DEPTH_LOG2-1:0] rd_ptr_d [2];
    logic [DEPTH_LOG2:0]   level_q [2];
    logic [DEPTH_LOG2:0]   level_d [2];
    logic [1:0]            full_q, full_d;
    logic [1:0]            ovf_q, ovf_d;
    state_t                state_q, state_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  owner_q, owner_d;
    logic                  active_q, active_d;
    logic                  last_grant_q, last_grant_d;

    logic [1:0] wr, nonempty, push, pop;
    logic [7:0] wdata [2];
    logic       issue, sel;

    always_comb begin
        wr       = {req1_wr, req0_wr};
        wdata[0] = req0_data;
        wdata[1] = req1_data;
        for (int i = 0; i < 2; i++) nonempty[i] = (level_q[i] != '0);
        issue = (state_q == ST_IDLE) && !tx_busy && (nonempty != 2'b00);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        sel = !nonempty[0];
`else
        sel = (nonempty == 2'b11) ? !last_grant_q : !nonempty[0];
`endif
        mem_d = mem_q;
        for (int i = 0; i < 2; i++) begin
            // Fullness is judged on the pre-pop level, so a push on a full FIFO drops even when popped.
            push[i]     = wr[i] && (level_q[i] != DEPTH_LVL);
            pop[i]      = issue && (sel == (i == 1));
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = wdata[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + DEPTH_LOG2'(1);
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + DEPTH_LOG2'(1);
            level_d[i] = level_q[i] + (DEPTH_LOG2 + 1)'(push[i]) - (DEPTH_LOG2 + 1)'(pop[i]);
            full_d[i]  = (level_d[i] == DEPTH_LVL);
        end
        ovf_d = (ovf_q & ~ovf_clr) | (wr & ~push);

        state_d      = state_q;
        tx_start_d   = issue;
        tx_data_d    = tx_data_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: if (issue) begin
                state_d      = ST_WAIT;
                tx_data_d    = mem_q[sel][rd_ptr_q[sel]];
                owner_d      = sel;
                last_grant_d = sel;
            end
            ST_WAIT: if (tx_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        active_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            owner_q      <= 1'b0;
            active_q     <= 1'b0;
            last_grant_q <= 1'b1;
            ovf_q        <= 2'b00;
            full_q       <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                level_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            owner_q      <= owner_d;
            active_q     <= active_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            full_q       <= full_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                level_q[i]  <= level_d[i];
            end
        end
    end

    // Storage needs no reset: the emptied pointers make stale contents unreachable.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign req0_level = level_q[0];
    assign req1_level = level_q[1];
    assign req0_full  = full_q[0];
    assign req1_full  = full_q[1];
    assign ovf        = ovf_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign owner      = owner_q;
    assign active     = active_q;
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-requester transmit arbiter placed in front of the UART transmitter core. Each requester (CPU-side UART controller path and debug/monitor path) pushes bytes into its own small FIFO. The block picks one byte at a time, issues it to the transmitter with a one-cycle `tx_start` pulse, and waits for `tx_end` before issuing the next. Requester ownership is tracked per byte; bytes are never interleaved mid-frame.

## Interface
- `DEPTH_LOG2`, 2, log2 of per-requester FIFO depth (depth = 4)
- `clk`  in  1  system clock
- `reset`  in  1  one clock; reset is synchronous and active-low
- `req0_wr`  in  1  push strobe, requester 0
- `req0_data`  in  8  byte to push, requester 0
- `req0_level`  out  DEPTH_LOG2+1  FIFO occupancy, requester 0
- `req0_full`  out  1  `req0_level` == depth
- `req1_wr`, `req1_data`, `req1_level`, `req1_full`: same as requester 0
- `ovf_clr`  in  2  per-requester overflow clear, bit i clears `ovf[i]`
- `ovf`  out  2  sticky overflow flag, bit i = requester i dropped a push
- `tx_busy`  in  1  transmitter busy
- `tx_end`  in  1  transmitter frame-done pulse
- `tx_start`  out  1  one-cycle issue pulse to transmitter
- `tx_data`  out  8  byte issued; held until next issue
- `owner`  out  1  requester of the byte most recently issued
- `active`  out  1  high while state = WAIT

## Operation
- States: IDLE, WAIT.
- IDLE → WAIT on an edge where all of these hold: `tx_busy`=0, `reset` high, at least one FIFO non-empty. On that edge:
  - select requester
  - pop its head
  - `tx_data` ← head, `tx_start` ← 1, `owner` ← selected
- WAIT: `tx_start` ← 0 on the next edge. WAIT → IDLE on an edge with `tx_end`=1. `tx_end` is ignored in IDLE.
- Selection (default, round-robin):
  - one FIFO non-empty → that requester
  - both non-empty → requester ≠ `last_grant`
  - `last_grant` ← selected on each issue; `last_grant` resets to 1, so requester 0 wins the first contention.
- FIFOs: circular, pointers wrap modulo depth. `reqN_level` counts 0..depth.
- Push while full: byte dropped, `ovf[N]` ← 1. Fullness is evaluated before any same-cycle pop, so a push on a full FIFO is dropped even if that FIFO is popped on the same edge.
- Push and pop on the same non-full FIFO, same edge: both take effect, level unchanged.
- `ovf` set and `ovf_clr` on the same edge: set wins.
- Reset (`reset`=0 at posedge):
  - state IDLE, FIFOs emptied
  - `tx_start`=0, `tx_data`=0, `owner`=0, `active`=0, `ovf`=0, `last_grant`=1
  - pushes on a reset edge are discarded
  - an in-flight frame is not aborted; the `tx_busy` gate prevents reissue until the transmitter is idle.

## Timing
- All outputs registered; `reqN_level`/`reqN_full` reflect pushes one cycle after the push edge.
- Push at edge k into an empty FIFO, IDLE, `tx_busy`=0:
  - issue edge k+1
  - `tx_start` high during cycle k+1→k+2 only
  - `active` high from k+1
- `tx_end` sampled at edge m → IDLE at m. Next issue edge is m+1 at earliest, giving a minimum 1-cycle IDLE gap.
- `tx_start` is never high for more than one cycle and never asserted while `active` was high on the prior edge.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, requester 0 always wins when non-empty; `last_grant` unused (still reset, updated).
  - Undefined: round-robin as above.
- Interface and timing are identical in both builds.

## Test plan
- Reset then single byte: `reset`=0 two cycles, release; push 8'hA5 on req0. Required response:
  - `tx_start`=1 exactly one cycle, `tx_data`=8'hA5, `owner`=0, `active`=1
  - after `tx_end` pulse: `active`=0, `req0_level`=0.
- Round-robin contention: push 8'h10, 8'h11 on req0 and 8'h20, 8'h21 on req1 in the same cycles, with the transmitter model answering `tx_end` 10 cycles after each start. Required issue order is 10, 20, 11, 21 (with `UART_TX_ARB_FIXED_PRIO_EN`: 10, 11, 20, 21).
- Overflow: `tx_busy`=1 held; push 5 bytes on req1. Required response:
  - `req1_level`=4, `req1_full`=1, `ovf`=2'b10
  - then `ovf_clr`=2'b10 → `ovf`=0
  - after release, the first 4 bytes are issued in order and the 5th is never issued.
- Busy gating after reset: assert reset while in WAIT with `tx_busy`=1; push 8'h3C after release. Required response: no `tx_start` until `tx_busy` falls; issue on the first edge with `tx_busy`=0.
- Wrap-around and simultaneous push/pop: stream 9 bytes into req0 with one push per cycle while draining. Required response: the pointers wrap twice, output order is preserved, and the level stays unchanged on edges with both push and pop.
